// File: rtl/mul_share_pkg.sv
// mul_share_arbiter shared types and constants.
// Operand/product widths, default latency and the result FIFO entry.
package mul_share_pkg;

  localparam int MUL_W        = 16;
  localparam int PROD_W       = 32;
  localparam int MULT_LAT_DEF = 4;
  localparam int NREQ_DEF     = 4;
  localparam int ID_W         = $clog2(NREQ_DEF);

  typedef struct packed {
    logic [ID_W-1:0]   id;
    logic [PROD_W-1:0] product;
  } resp_entry_t;

endpackage

// File: rtl/mul_share_if.sv
// Requester, multiplier and response bundle of mul_share_arbiter.
// slave is the arbiter side, master the environment side.
interface mul_share_if
  import mul_share_pkg::*;
#(
  parameter int NREQ = 4,
  parameter int IDW  = 2,
  parameter int CW   = 4
);

  logic [NREQ-1:0]       req_valid;
  logic [NREQ-1:0]       req_ready;
  logic [NREQ*MUL_W-1:0] req_a;
  logic [NREQ*MUL_W-1:0] req_b;
  logic [MUL_W-1:0]      mul_a;
  logic [MUL_W-1:0]      mul_b;
  logic [PROD_W-1:0]     mul_product;
  logic                  resp_valid;
  logic                  resp_ready;
  logic [IDW-1:0]        resp_id;
  logic [PROD_W-1:0]     resp_product;
  logic [CW-1:0]         inflight;

  modport slave (
    input  req_valid, req_a, req_b,
    input  mul_product, resp_ready,
    output req_ready, mul_a, mul_b,
    output resp_valid, resp_id,
    output resp_product, inflight
  );

  modport master (
    output req_valid, req_a, req_b,
    output mul_product, resp_ready,
    input  req_ready, mul_a, mul_b,
    input  resp_valid, resp_id,
    input  resp_product, inflight
  );

endinterface

// File: rtl/mul_share_arbiter_rr.sv
// Round-robin arbiter: search starts one past the last winner.
// The pointer moves only when the grant is actually used.
module rr_arbiter #(
  parameter int NREQ = 4,
  parameter int IDW  = $clog2(NREQ)
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic [NREQ-1:0] req,
  input  logic            advance,
  output logic [NREQ-1:0] grant,
  output logic [IDW-1:0]  grant_idx
);

  logic [IDW-1:0] rr_ptr;

  // Walk from farthest to nearest so the nearest requester wins.
  always_comb begin
    grant     = '0;
    grant_idx = '0;
    for (int k = NREQ; k >= 1; k--) begin
      if (req[(int'(rr_ptr) + k) % NREQ]) begin
        grant = '0;
        grant[(int'(rr_ptr) + k) % NREQ] = 1'b1;
        grant_idx = IDW'((int'(rr_ptr) + k) % NREQ);
      end
    end
  end

  // Remember the last winner; reset value gives requester 0 priority.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)
      rr_ptr <= IDW'(NREQ - 1);
    else if (advance)
      rr_ptr <= grant_idx;
  end

endmodule

// File: rtl/mul_share_arbiter.sv
// Shares one fixed-latency multiplier between NREQ requesters.
// Credits cover tags in flight plus FIFO entries so nothing overflows.
module mul_share_arbiter
  import mul_share_pkg::*;
#(
  parameter int NREQ       = NREQ_DEF,
  parameter int IDW        = ID_W,
  parameter int MULT_LAT   = MULT_LAT_DEF,
  parameter int FIFO_DEPTH = 8
) (
  input  logic        clk,
  input  logic        rst_n,
  mul_share_if.slave  bus
);

  localparam int CW = $clog2(FIFO_DEPTH) + 1;
  localparam int PW = $clog2(FIFO_DEPTH);

  logic             issue;
  logic             push;
  logic             pop;
  logic [NREQ-1:0]  grant;
  logic [IDW-1:0]   gidx;
  logic [CW-1:0]    inflight;
  logic [CW-1:0]    count;
  logic [PW-1:0]    wr_ptr;
  logic [PW-1:0]    rd_ptr;
  logic [MUL_W-1:0] a_arr [NREQ];
  logic [MUL_W-1:0] b_arr [NREQ];

  logic [MULT_LAT-1:0] tag_v;
  logic [IDW-1:0]      tag_id [MULT_LAT];

  resp_entry_t mem [FIFO_DEPTH];
  resp_entry_t head;

  for (genvar i = 0; i < NREQ; i++) begin : g_unpack
    assign a_arr[i] = bus.req_a[i*MUL_W +: MUL_W];
    assign b_arr[i] = bus.req_b[i*MUL_W +: MUL_W];
  end

  assign issue = rst_n && (|bus.req_valid) &&
                 (inflight < CW'(FIFO_DEPTH));

  rr_arbiter #(
    .NREQ (NREQ),
    .IDW  (IDW)
  ) u_arb (
    .clk       (clk),
    .rst_n     (rst_n),
    .req       (bus.req_valid),
    .advance   (issue),
    .grant     (grant),
    .grant_idx (gidx)
  );

  assign bus.req_ready = issue ? grant : '0;
  assign bus.mul_a     = issue ? a_arr[gidx] : '0;
  assign bus.mul_b     = issue ? b_arr[gidx] : '0;

  assign push = tag_v[MULT_LAT-1];
  assign pop  = bus.resp_valid && bus.resp_ready;
  assign head = mem[rd_ptr];

  assign bus.resp_valid   = (count != '0);
  assign bus.resp_id      = bus.resp_valid ? IDW'(head.id) : '0;
  assign bus.resp_product = bus.resp_valid ? head.product : '0;
  assign bus.inflight     = inflight;

  // Tag shift register tracks which requester owns each product.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      tag_v <= '0;
      for (int i = 0; i < MULT_LAT; i++)
        tag_id[i] <= '0;
    end else begin
      tag_v     <= {tag_v[MULT_LAT-2:0], issue};
      tag_id[0] <= gidx;
      for (int i = 1; i < MULT_LAT; i++)
        tag_id[i] <= tag_id[i-1];
    end
  end

  // Result storage; validity is tracked by the pointers alone.
  always_ff @(posedge clk) begin
    if (push)
      mem[wr_ptr] <= '{id: ID_W'(tag_id[MULT_LAT-1]),
                       product: bus.mul_product};
  end

  // FIFO pointers and occupancy.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push)
        wr_ptr <= wr_ptr + 1'b1;
      if (pop)
        rd_ptr <= rd_ptr + 1'b1;
      unique case ({push, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  // Credit counter: issued but not yet popped.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)
      inflight <= '0;
    else
      unique case ({issue, pop})
        2'b10:   inflight <= inflight + 1'b1;
        2'b01:   inflight <= inflight - 1'b1;
        default: inflight <= inflight;
      endcase
  end

endmodule

// File: tb/tb_mul_share_arbiter.sv
// Scoreboard bench for mul_share_arbiter with a behavioural multiplier.
// Expected grants and products come from a round-robin reference model.
module tb_mul_share_arbiter;
  import mul_share_pkg::*;

  localparam int N     = 4;
  localparam int LAT   = 4;
  localparam int DEPTH = 8;
  localparam int OPS   = 256;

  typedef struct {
    logic [1:0]  id;
    logic [31:0] p;
    int          cyc;
  } exp_t;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  mul_share_if #(.NREQ(N), .IDW(2), .CW(4)) bus ();

  mul_share_arbiter #(
    .NREQ       (N),
    .IDW        (2),
    .MULT_LAT   (LAT),
    .FIFO_DEPTH (DEPTH)
  ) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  int total = 0;
  int bad   = 0;
  int cyc   = 0;
  int occ_seen = 0;
  int last  = N - 1;

  logic [15:0]  ta [N];
  logic [15:0]  tbv [N];
  logic [N-1:0] tv;
  logic [N-1:0] acc;
  logic         rdy;
  logic         rand_rdy;
  logic [31:0]  ops [N][OPS];
  int           hd [N];
  int           tl [N];
  exp_t         expq [$];
  logic [31:0]  pipe [LAT];

  for (genvar i = 0; i < N; i++) begin : g_pack
    assign bus.req_a[16*i +: 16] = ta[i];
    assign bus.req_b[16*i +: 16] = tbv[i];
  end
  assign bus.req_valid   = tv;
  assign bus.resp_ready  = rdy;
  assign bus.mul_product = pipe[LAT-1];

  // Fixed-latency multiplier, no enable, no reset.
  always @(posedge clk) begin
    pipe[0] <= 32'(bus.mul_a) * 32'(bus.mul_b);
    for (int i = 1; i < LAT; i++)
      pipe[i] <= pipe[i-1];
  end

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(string nm, logic [31:0] act,
                     logic [31:0] want);
    total++;
    if (act !== want) begin
      bad++;
      $display("FAIL %s: got %h want %h at cycle %0d",
               nm, act, want, cyc);
    end
  endtask

  task automatic refresh();
    for (int i = 0; i < N; i++) begin
      if (hd[i] < tl[i]) begin
        tv[i]  = 1'b1;
        ta[i]  = ops[i][hd[i]][31:16];
        tbv[i] = ops[i][hd[i]][15:0];
      end else begin
        tv[i]  = 1'b0;
        ta[i]  = '0;
        tbv[i] = '0;
      end
    end
  endtask

  task automatic add(int i, logic [15:0] a, logic [15:0] b);
    ops[i][tl[i]] = {a, b};
    tl[i]++;
    refresh();
  endtask

  task automatic step();
    @(posedge clk);
    #1;
    for (int i = 0; i < N; i++)
      if (acc[i]) hd[i]++;
    if (rand_rdy) rdy = 1'($urandom_range(0, 1));
    refresh();
  endtask

  function automatic bit busy();
    bit b;
    b = expq.size() > 0;
    for (int i = 0; i < N; i++)
      if (hd[i] < tl[i]) b = 1'b1;
    return b;
  endfunction

  task automatic wait_idle(int lim);
    int n;
    n = 0;
    while (busy() && n < lim) begin
      step();
      n++;
    end
    if (n >= lim) begin
      total++;
      bad++;
      $display("FAIL idle_timeout: got busy want idle");
    end
    repeat (2) step();
  endtask

  // Reference model: round-robin pick, credit limit, expected result.
  always @(negedge clk) begin
    #1;
    if (!rst_n) begin
      last = N - 1;
      acc  = '0;
      chk("req_ready_rst", 32'(bus.req_ready), 0);
    end else begin
      bit         iss;
      int         g;
      logic [3:0] er;
      iss = (|tv) && (occ_seen < DEPTH);
      g = 0;
      for (int k = N; k >= 1; k--)
        if (tv[(last + k) % N]) g = (last + k) % N;
      er = iss ? 4'(1 << g) : 4'd0;
      chk("req_ready", 32'(bus.req_ready), 32'(er));
      chk("mul_a", 32'(bus.mul_a), iss ? 32'(ta[g]) : 0);
      chk("mul_b", 32'(bus.mul_b), iss ? 32'(tbv[g]) : 0);
      acc = bus.req_ready;
      if (iss) begin
        expq.push_back('{id: 2'(g),
                         p: 32'(ta[g]) * 32'(tbv[g]),
                         cyc: cyc});
        last = g;
      end
    end
  end

  // Monitor: checks response port and credits against the scoreboard.
  always @(negedge clk) begin
    if (!rst_n) begin
      expq.delete();
      occ_seen = 0;
      chk("resp_valid_rst", 32'(bus.resp_valid), 0);
      chk("resp_id_rst", 32'(bus.resp_id), 0);
      chk("resp_product_rst", bus.resp_product, 0);
      chk("inflight_rst", 32'(bus.inflight), 0);
      chk("mul_a_rst", 32'(bus.mul_a), 0);
      chk("mul_b_rst", 32'(bus.mul_b), 0);
    end else begin
      bit ev;
      chk("inflight", 32'(bus.inflight), 32'(expq.size()));
      occ_seen = expq.size();
      ev = (expq.size() > 0) && (cyc >= expq[0].cyc + LAT + 1);
      chk("resp_valid", 32'(bus.resp_valid), 32'(ev));
      if (ev) begin
        chk("resp_id", 32'(bus.resp_id), 32'(expq[0].id));
        chk("resp_product", bus.resp_product, expq[0].p);
        if (rdy) void'(expq.pop_front());
      end else begin
        chk("resp_id_idle", 32'(bus.resp_id), 0);
        chk("resp_product_idle", bus.resp_product, 0);
      end
    end
  end

  initial begin
    rdy = 1'b1;
    rand_rdy = 1'b0;
    acc = '0;
    for (int i = 0; i < N; i++) begin
      hd[i] = 0;
      tl[i] = 0;
    end
    refresh();
    repeat (3) step();
    rst_n = 1'b1;
    step();

    add(0, 16'h0003, 16'h0005);
    wait_idle(50);

    for (int r = 0; r < 3; r++)
      for (int i = 0; i < N; i++)
        add(i, 16'(i + 1), 16'hFFFF);
    wait_idle(100);

    rdy = 1'b0;
    for (int k = 0; k < 12; k++)
      add(2, 16'(k + 7), 16'(3 * k + 1));
    repeat (20) step();
    @(negedge clk);
    chk("credit_inflight", 32'(bus.inflight), 8);
    chk("credit_ready", 32'(bus.req_ready), 0);
    step();
    rdy = 1'b1;
    wait_idle(100);

    add(1, 16'hFFFF, 16'hFFFF);
    add(3, 16'h0000, 16'hABCD);
    add(0, 16'h8000, 16'h0002);
    wait_idle(50);

    for (int k = 0; k < 20; k++)
      add(1, 16'(k * 977), 16'(k + 100));
    wait_idle(100);

    rand_rdy = 1'b1;
    for (int k = 0; k < 60; k++) begin
      logic [15:0] a;
      logic [15:0] b;
      a = 16'($urandom);
      b = 16'($urandom);
      if ($urandom_range(0, 7) == 0) a = 16'hFFFF;
      if ($urandom_range(0, 7) == 0) b = 16'h0000;
      add($urandom_range(0, N - 1), a, b);
      repeat ($urandom_range(0, 2)) step();
    end
    wait_idle(1000);
    rand_rdy = 1'b0;
    rdy = 1'b1;
    step();

    for (int k = 0; k < 3; k++)
      add(3, 16'(k + 2), 16'h1111);
    repeat (5) step();
    rst_n = 1'b0;
    step();
    rst_n = 1'b1;
    repeat (6) step();
    add(2, 16'h1234, 16'h0010);
    wait_idle(50);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
